imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
Boot-time writer for the instruction memory the datapath fetches from. It accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words. Each word is written to consecutive word-aligned byte addresses starting at 0. The core is held in reset until the image is fully loaded.

Parameters:
ADDR_W, 8, word-address width; memory capacity is 2**ADDR_W words.
LEN_W, 16, width of the word-count header field (fixed at 2 header bytes; LEN_W must be 16).

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
start  input  1  single-cycle pulse; begins a load from IDLE or DONE
in_data  input  8  stream byte
in_valid  input  1  in_data is valid this cycle
in_ready  output  1  loader accepts a byte this cycle
mem_we  output  1  instruction-memory write enable, one cycle per word
mem_addr  output  32  byte address, word aligned (word_index << 2)
mem_wdata  output  32  instruction word
core_hold  output  1  high keeps the datapath reset asserted
done  output  1  load finished; sticky until the next start
err  output  1  header word count exceeded capacity; sticky until the next start

Behaviour:
- One clock domain: clk. reset is asynchronous and active-high.
- Reset values: state=IDLE, in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, core_hold=1, done=0, err=0. Internal counters are cleared.
- A byte is accepted only when in_valid && in_ready in the same cycle. in_data is sampled on that edge.
- Stream format: LEN_LO, then LEN_HI, giving word count N; then N*4 data bytes. Each word arrives least-significant byte first.
- States:
  - IDLE: in_ready=0, core_hold=1. start -> LEN_LO.
  - LEN_LO: in_ready=1. On accept, latch the low byte of N -> LEN_HI.
  - LEN_HI: in_ready=1. On accept, form N.
    - N==0 -> DONE.
    - N > 2**ADDR_W -> DONE with err=1 and no writes.
    - Otherwise -> DATA, with word_index=0 and byte_index=0.
  - DATA: in_ready=1. On each accept, shift the byte into lane byte_index and increment byte_index. The 4th accepted byte -> WRITE.
  - WRITE: in_ready=0. mem_we=1 for exactly this cycle, with mem_addr=word_index<<2 and mem_wdata=the assembled word. Then word_index increments.
    - If word_index+1 == N -> DONE; else -> DATA.
  - DONE: in_ready=0, done=1, core_hold=0. start -> LEN_LO, clearing done/err and raising core_hold on the same edge.
- Latency: a 4th data byte accepted at edge k drives mem_we high for the cycle following edge k. Peak throughput is one word per 5 cycles.
- mem_we, mem_addr and mem_wdata are registered. mem_addr and mem_wdata hold their last values when mem_we=0.
- start outside IDLE/DONE is ignored.
- in_valid without in_ready is ignored. The source holds in_data, and no byte is consumed.
- Reset mid-load: return to IDLE with the reset values above. Words already written remain in memory, and the bench must not rely on them.
- mem_addr wrap cannot occur, because N ≤ 2**ADDR_W is enforced. The last address is (2**ADDR_W-1)<<2.
- Upper bits of mem_addr above ADDR_W+2 are always 0.

Decomposition:
- Package imem_loader_pkg holds:
  - the state enum {IDLE, LEN_LO, LEN_HI, DATA, WRITE, DONE};
  - BYTES_PER_WORD=4 and HDR_BYTES=2.
- Sub-module word_assembler:
  - 8-bit in, 32-bit little-endian shift register with a 2-bit lane counter;
  - outputs word_full and word.
- imem_loader keeps the FSM, the word-count and word-index counters, and the memory-port registers.

Test Plan:
- Reset then idle: assert reset for 3 cycles -> core_hold=1, in_ready=0, mem_we=0, done=0. With no start, no writes ever occur.
- Single word: start; bytes 01 00 13 05 A0 00 -> one mem_we pulse with addr=0x0 and wdata=0x00A00513, the cycle after byte 6. Then done=1 and core_hold=0.
- Three words with in_valid gaps (random 0–3 idle cycles between bytes) -> writes to 0x0, 0x4 and 0x8 with correct words. in_ready=0 during each WRITE cycle. Exactly 3 mem_we pulses.
- Header N=0 (00 00) -> DONE in the cycle after the 2nd byte, no mem_we, err=0. Header N=257 with ADDR_W=8 (01 01) -> done=1, err=1, no mem_we. A following start clears err.
- Capacity edge: N=256 -> last write has addr=0x3FC. Then DONE; no 257th write.
- Reset mid-load: assert reset after 2 of 4 data bytes of word 1 -> outputs return to reset values immediately (asynchronously). A fresh start and image reload from address 0 succeeds. A start pulsed during DATA has no effect.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared types and constants for the instruction-memory
// boot loader.
//   state_t        - loader FSM states
//   BYTES_PER_WORD - stream bytes per instruction word
//   HDR_BYTES      - bytes in the word-count header
package imem_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        DATA,
        WRITE,
        DONE
    } state_t;

    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned HDR_BYTES      = 2;

endpackage

// File: rtl/imem_loader_word_assembler.sv
// word_assembler: collects stream bytes into a little-endian 32-bit word.
//   clk, reset - clock, asynchronous active-high reset
//   clear      - return the lane counter to byte 0
//   shift_en   - a byte is accepted this cycle
//   in_data    - accepted byte
//   word_full  - the byte accepted this cycle completes a word
//   word       - assembled word; valid while word_full is high
module word_assembler
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        shift_en,
    input  logic [7:0]  in_data,
    output logic        word_full,
    output logic [31:0] word
);

    logic [23:0] low_bytes;
    logic [1:0]  lane;

    // Bytes shift in from the top, so after three shifts the first byte sits
    // in bits [7:0]; the fourth byte is appended combinationally so the full
    // word can be registered on the same edge that accepts it.
    assign word      = {in_data, low_bytes};
    assign word_full = shift_en && (lane == 2'(BYTES_PER_WORD - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            low_bytes <= '0;
            lane      <= '0;
        end else if (clear) begin
            lane      <= '0;
        end else if (shift_en) begin
            low_bytes <= {in_data, low_bytes[23:8]};
            lane      <= lane + 2'd1;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// imem_loader: boot-time writer for the instruction memory. Receives a byte
// stream (2-byte little-endian word count N, then N little-endian words) and
// writes each word to consecutive word-aligned addresses starting at 0,
// holding the core in reset until the image is loaded.
//   clk, reset          - clock, asynchronous active-high reset
//   start               - pulse; begins a load from IDLE or DONE
//   in_data/valid/ready - byte stream handshake
//   mem_we/addr/wdata   - registered instruction-memory write port
//   core_hold           - keeps the datapath in reset
//   done, err           - sticky status until the next start
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned LEN_W  = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        core_hold,
    output logic        done,
    output logic        err
);

    localparam logic [31:0] CAPACITY = 32'(1) << ADDR_W;

    state_t              state;
    logic [7:0]          len_lo;
    logic [LEN_W-1:0]    word_count;
    logic [ADDR_W-1:0]   word_index;
    logic                accept;
    logic [LEN_W-1:0]    hdr_count;
    logic                word_full;
    logic [31:0]         word;
    logic                last_word;

    assign accept    = in_valid && in_ready;
    assign hdr_count = LEN_W'({in_data, len_lo});
    assign last_word = (LEN_W'(word_index) + LEN_W'(1)) == word_count;

    word_assembler u_asm (
        .clk      (clk),
        .reset    (reset),
        .clear    (state == LEN_HI && accept),
        .shift_en (state == DATA && accept),
        .in_data  (in_data),
        .word_full(word_full),
        .word     (word)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            in_ready   <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            core_hold  <= 1'b1;
            done       <= 1'b0;
            err        <= 1'b0;
            len_lo     <= '0;
            word_count <= '0;
            word_index <= '0;
        end else begin
            mem_we <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= LEN_LO;
                        in_ready <= 1'b1;
                    end
                end
                LEN_LO: begin
                    if (accept) begin
                        len_lo <= in_data;
                        state  <= LEN_HI;
                    end
                end
                LEN_HI: begin
                    if (accept) begin
                        word_count <= hdr_count;
                        word_index <= '0;
                        if (hdr_count == '0 || 32'(hdr_count) > CAPACITY) begin
                            state     <= DONE;
                            in_ready  <= 1'b0;
                            done      <= 1'b1;
                            core_hold <= 1'b0;
                            err       <= (hdr_count != '0);
                        end else begin
                            state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (word_full) begin
                        state     <= WRITE;
                        in_ready  <= 1'b0;
                        mem_we    <= 1'b1;
                        mem_addr  <= 32'({word_index, 2'b00});
                        mem_wdata <= word;
                    end
                end
                WRITE: begin
                    word_index <= word_index + ADDR_W'(1);
                    if (last_word) begin
                        state     <= DONE;
                        done      <= 1'b1;
                        core_hold <= 1'b0;
                    end else begin
                        state    <= DATA;
                        in_ready <= 1'b1;
                    end
                end
                DONE: begin
                    if (start) begin
                        state     <= LEN_LO;
                        in_ready  <= 1'b1;
                        done      <= 1'b0;
                        err       <= 1'b0;
                        core_hold <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: scoreboard bench for imem_loader. Expected writes are
// queued as words are driven and popped by a monitor on each mem_we pulse.
module tb_imem_loader;

    logic        clk;
    logic        reset;
    logic        start;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        core_hold;
    logic        done;
    logic        err;

    imem_loader #(.ADDR_W(8), .LEN_W(16)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .core_hold(core_hold),
        .done     (done),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t         exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          we_count = 0;
    logic [31:0] last_addr = '0;
    logic [31:0] next_addr = '0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Write monitor: every pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            wr_t e;
            we_count++;
            last_addr = mem_addr;
            check_eq("ready_in_write", 32'(in_ready), 32'd0);
            if (exp_q.size() == 0) begin
                check_eq("unexpected_write", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check_eq("wr_addr", mem_addr, e.addr);
                check_eq("wr_data", mem_wdata, e.data);
            end
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Returns 1 ns after the edge on which the byte was accepted.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        in_valid = 1'b0;
        repeat (gap) @(posedge clk);
        #1;
        in_data  = b;
        in_valid = 1'b1;
        n = 0;
        forever begin
            @(posedge clk);
            n++;
            if (in_ready) break;
            if (n >= 50) begin
                check_eq("accept_timeout", 32'd0, 32'd1);
                break;
            end
        end
        #1 in_valid = 1'b0;
    endtask

    task automatic send_header(input logic [15:0] n, input int maxgap);
        logic [15:0] v;
        v = n;
        next_addr = '0;
        send_byte(v[7:0], $urandom_range(maxgap, 0));
        send_byte(v[15:8], $urandom_range(maxgap, 0));
    endtask

    task automatic send_word(input logic [31:0] w, input int maxgap);
        wr_t e;
        logic [31:0] v;
        v = w;
        e.addr = next_addr;
        e.data = w;
        exp_q.push_back(e);
        next_addr = next_addr + 32'd4;
        for (int i = 0; i < 4; i++)
            send_byte(v[8*i +: 8], $urandom_range(maxgap, 0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int base;

    initial begin
        reset = 1'b1; start = 1'b0; in_data = '0; in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state, then idle with no start.
        check_eq("rst_core_hold", 32'(core_hold), 32'd1);
        check_eq("rst_in_ready", 32'(in_ready), 32'd0);
        check_eq("rst_mem_we", 32'(mem_we), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_err", 32'(err), 32'd0);
        in_valid = 1'b1; in_data = 8'h5A;
        repeat (10) @(posedge clk);
        #1 in_valid = 1'b0;
        check_eq("idle_no_writes", 32'(we_count), 32'd0);
        check_eq("idle_in_ready", 32'(in_ready), 32'd0);

        // Single word: 01 00 13 05 A0 00.
        pulse_start();
        check_eq("start_ready", 32'(in_ready), 32'd1);
        send_header(16'd1, 0);
        send_word(32'h00A00513, 0);
        check_eq("lat_mem_we", 32'(mem_we), 32'd1);
        check_eq("lat_addr", mem_addr, 32'h0);
        check_eq("lat_wdata", mem_wdata, 32'h00A00513);
        @(posedge clk); #1;
        check_eq("single_done", 32'(done), 32'd1);
        check_eq("single_core_hold", 32'(core_hold), 32'd0);
        check_eq("single_count", 32'(we_count), 32'd1);

        // Three words with random gaps.
        base = we_count;
        pulse_start();
        check_eq("restart_done_clr", 32'(done), 32'd0);
        check_eq("restart_hold", 32'(core_hold), 32'd1);
        send_header(16'd3, 3);
        for (int i = 0; i < 3; i++) send_word($urandom, 3);
        repeat (3) @(posedge clk); #1;
        check_eq("three_count", 32'(we_count - base), 32'd3);
        check_eq("three_done", 32'(done), 32'd1);
        check_eq("three_sb_empty", 32'(exp_q.size()), 32'd0);

        // Empty image.
        base = we_count;
        pulse_start();
        send_header(16'd0, 0);
        check_eq("n0_done", 32'(done), 32'd1);
        check_eq("n0_err", 32'(err), 32'd0);
        check_eq("n0_ready", 32'(in_ready), 32'd0);

        // Oversized image.
        pulse_start();
        send_header(16'd257, 0);
        check_eq("n257_done", 32'(done), 32'd1);
        check_eq("n257_err", 32'(err), 32'd1);
        repeat (5) @(posedge clk); #1;
        check_eq("n_edge_no_writes", 32'(we_count - base), 32'd0);
        pulse_start();
        check_eq("err_cleared", 32'(err), 32'd0);

        // Capacity edge: N=256 (loader already in LEN_LO).
        base = we_count;
        send_header(16'd256, 0);
        for (int i = 0; i < 256; i++) send_word($urandom, 0);
        repeat (10) @(posedge clk); #1;
        check_eq("cap_count", 32'(we_count - base), 32'd256);
        check_eq("cap_last_addr", last_addr, 32'h3FC);
        check_eq("cap_done", 32'(done), 32'd1);
        check_eq("cap_err", 32'(err), 32'd0);

        // Reset mid-load after 2 data bytes of the first word.
        pulse_start();
        send_header(16'd2, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        #2 reset = 1'b1;
        #1;
        exp_q.delete();
        check_eq("mid_rst_ready", 32'(in_ready), 32'd0);
        check_eq("mid_rst_hold", 32'(core_hold), 32'd1);
        check_eq("mid_rst_addr", mem_addr, 32'h0);
        check_eq("mid_rst_wdata", mem_wdata, 32'h0);
        check_eq("mid_rst_done", 32'(done), 32'd0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Reload; a start pulse during DATA must be ignored.
        base = we_count;
        pulse_start();
        send_header(16'd2, 1);
        pulse_start();
        send_word(32'hDEADBEEF, 1);
        pulse_start();
        send_word(32'h12345678, 1);
        repeat (3) @(posedge clk); #1;
        check_eq("reload_count", 32'(we_count - base), 32'd2);
        check_eq("reload_last_addr", last_addr, 32'h4);
        check_eq("reload_done", 32'(done), 32'd1);
        check_eq("final_sb_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
